// File: rtl/ntt_mem_sched_pkg.sv
// Shared types and helpers for the NTT memory scheduler: FSM states,
// pipeline-latency derivation and a width-generic rotate-left.
package ntt_mem_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Butterfly latency plus one cycle for the BRAM registered read.
  function automatic int pipe_lat(input int bfly_lat);
    return bfly_lat + 1;
  endfunction

  // Rotate the low w bits of v left by n; bits at or above w come back as zero.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[(i + n) % w] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Parameterised WIDTH x DEPTH shift register with asynchronous clear, used to
// align write-back addresses with the butterfly pipeline.
module ntt_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] q;
      if (gi == 0) begin : g_in
        assign d = din;
      end else begin : g_chain
        assign d = g_tap[gi-1].q;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
      end
    end
  endgenerate

  assign dout = g_tap[DEPTH-1].q;

endmodule

// File: rtl/ntt_mem_sched.sv
// In-place radix-2 NTT address scheduler: one read per cycle per stage, with
// a drain gap between stages so write-back never races the next stage's reads.
module ntt_mem_sched
  import ntt_mem_sched_pkg::*;
#(
  parameter int Q_DEPTH    = 8,
  parameter int NUM_STAGES = 8,
  parameter int BFLY_LAT   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [Q_DEPTH-1:0]              rd_addr,
  output logic [$clog2(NUM_STAGES+1)-1:0] stage,
  output logic [Q_DEPTH-1:0]              tw_idx,
  output logic                            wr_en,
  output logic [Q_DEPTH-1:0]              wr_addr
);

  localparam int PIPE_LAT = pipe_lat(BFLY_LAT);
  localparam int SW       = $clog2(NUM_STAGES + 1);
  localparam int DW       = $clog2(PIPE_LAT + 1);

  localparam logic [Q_DEPTH-1:0] C_LAST     = '1;
  localparam logic [SW-1:0]      STAGE_LAST = SW'(NUM_STAGES - 1);
  localparam logic [DW-1:0]      DRAIN_LAST = DW'(PIPE_LAT - 1);

  state_t             state_reg, state_next;
  logic [Q_DEPTH-1:0] c_reg, c_next;
  logic [SW-1:0]      stage_reg, stage_next;
  logic [DW-1:0]      drain_reg, drain_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      c_reg     <= '0;
      stage_reg <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      stage_reg <= stage_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    stage_next = stage_reg;
    drain_next = drain_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          c_next     = '0;
          stage_next = '0;
        end
      end
      ST_RUN: begin
        // Counter wraps naturally to zero, ready for the next stage.
        c_next = c_reg + 1'b1;
        if (c_reg == C_LAST) begin
          state_next = ST_DRAIN;
          drain_next = '0;
        end
      end
      ST_DRAIN: begin
        drain_next = drain_reg + 1'b1;
        if (drain_reg == DRAIN_LAST) begin
          drain_next = '0;
          if (stage_reg == STAGE_LAST) begin
            state_next = ST_DONE;
          end else begin
            stage_next = stage_reg + 1'b1;
            state_next = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        stage_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_en   = (state_reg == ST_RUN);
  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign stage   = stage_reg;
  assign rd_addr = Q_DEPTH'(rotl(32'(c_reg), int'(stage_reg), Q_DEPTH));
  assign tw_idx  = (stage_reg == '0) ? '0 : (c_reg >> (Q_DEPTH - int'(stage_reg)));

  logic [Q_DEPTH:0] line_out;

  ntt_delay_line #(
    .WIDTH(Q_DEPTH + 1),
    .DEPTH(PIPE_LAT)
  ) u_wr_delay (
    .clk (clk),
    .rst (rst),
    .din ({rd_en, rd_addr}),
    .dout(line_out)
  );

  assign wr_en   = line_out[Q_DEPTH];
  assign wr_addr = line_out[Q_DEPTH-1:0];

endmodule

// File: tb/tb_ntt_mem_sched.sv
// Scoreboard bench for ntt_mem_sched at Q_DEPTH=3, NUM_STAGES=3, BFLY_LAT=2:
// stimulus queues hand-computed read/write/done events, a monitor pops them.
module tb_ntt_mem_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [1:0] stage;
  logic [2:0] tw_idx;
  logic       wr_en;
  logic [2:0] wr_addr;

  ntt_mem_sched #(
    .Q_DEPTH(3),
    .NUM_STAGES(3),
    .BFLY_LAT(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .stage  (stage),
    .tw_idx (tw_idx),
    .wr_en  (wr_en),
    .wr_addr(wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int tw;
    int stg;
  } rd_t;

  typedef struct {
    int cyc;
    int addr;
  } wr_t;

  rd_t exp_rd[$];
  wr_t exp_wr[$];
  int  exp_done[$];

  int errors   = 0;
  int checks   = 0;
  int edge_cnt = 0;
  int run_base = -1;

  // Hand-computed per-read expectations, stage-major.
  int addr_tbl[24] = '{0, 1, 2, 3, 4, 5, 6, 7,
                       0, 2, 4, 6, 1, 3, 5, 7,
                       0, 4, 1, 5, 2, 6, 3, 7};
  int tw_tbl[24]   = '{0, 0, 0, 0, 0, 0, 0, 0,
                       0, 0, 0, 0, 1, 1, 1, 1,
                       0, 0, 1, 1, 2, 2, 3, 3};
  int stage_start[3] = '{1, 12, 23};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: pops one expectation per DUT event and checks busy every cycle.
  always @(negedge clk) begin : mon
    rd_t er;
    wr_t ew;
    int  ed;
    bit  exp_busy;
    if (rd_en) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected cyc=%0d addr=%0d", edge_cnt, rd_addr);
      end else begin
        er = exp_rd.pop_front();
        if (er.cyc != edge_cnt || er.addr != int'(rd_addr) || er.tw != int'(tw_idx) ||
            er.stg != int'(stage)) begin
          errors++;
          $display("FAIL rd got cyc=%0d addr=%0d tw=%0d stage=%0d want cyc=%0d addr=%0d tw=%0d stage=%0d",
                   edge_cnt, rd_addr, tw_idx, stage, er.cyc, er.addr, er.tw, er.stg);
        end else begin
          $display("rd cyc=%0d addr=%0d tw=%0d stage=%0d", edge_cnt, rd_addr, tw_idx, stage);
        end
      end
    end
    if (wr_en) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected cyc=%0d addr=%0d", edge_cnt, wr_addr);
      end else begin
        ew = exp_wr.pop_front();
        if (ew.cyc != edge_cnt || ew.addr != int'(wr_addr)) begin
          errors++;
          $display("FAIL wr got cyc=%0d addr=%0d want cyc=%0d addr=%0d",
                   edge_cnt, wr_addr, ew.cyc, ew.addr);
        end else begin
          $display("wr cyc=%0d addr=%0d", edge_cnt, wr_addr);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d", edge_cnt);
      end else begin
        ed = exp_done.pop_front();
        if (ed != edge_cnt) begin
          errors++;
          $display("FAIL done got cyc=%0d want cyc=%0d", edge_cnt, ed);
        end else begin
          $display("done cyc=%0d", edge_cnt);
        end
      end
    end
    exp_busy = (run_base >= 0) && (edge_cnt >= run_base + 1) && (edge_cnt <= run_base + 34);
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%0b want=%0b", edge_cnt, busy, exp_busy);
    end
  end

  task automatic push_run(input int base);
    rd_t er;
    wr_t ew;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        er.cyc  = base + stage_start[s] + i;
        er.addr = addr_tbl[s*8 + i];
        er.tw   = tw_tbl[s*8 + i];
        er.stg  = s;
        exp_rd.push_back(er);
        ew.cyc  = er.cyc + 3;
        ew.addr = er.addr;
        exp_wr.push_back(ew);
      end
    end
    exp_done.push_back(base + 34);
  endtask

  task automatic do_start(output int base);
    @(negedge clk);
    start = 1'b1;
    base  = edge_cnt;
    push_run(base);
    run_base = base;
    $display("start issued at cyc=%0d", base);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, rd_en, rd_addr, stage, tw_idx, wr_en, wr_addr} !== '0) begin
      errors++;
      $display("FAIL %s got busy=%0b done=%0b rd_en=%0b rd_addr=%0d stage=%0d tw=%0d wr_en=%0b wr_addr=%0d want all 0",
               name, busy, done, rd_en, rd_addr, stage, tw_idx, wr_en, wr_addr);
    end
  endtask

  // Expectations for cycles already past must have been consumed; later ones are cancelled.
  task automatic flush_queues();
    int stale;
    stale = 0;
    foreach (exp_rd[i]) if (exp_rd[i].cyc < edge_cnt) stale++;
    foreach (exp_wr[i]) if (exp_wr[i].cyc < edge_cnt) stale++;
    foreach (exp_done[i]) if (exp_done[i] < edge_cnt) stale++;
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL flush_stale got=%0d missed events want=0", stale);
    end
    exp_rd.delete();
    exp_wr.delete();
    exp_done.delete();
  endtask

  initial begin : stim
    int base;
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check_all_zero("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Idle: monitor flags any activity.
    repeat (20) @(negedge clk);
    check_all_zero("idle");

    // Plain run.
    do_start(base);
    wait_until(base + 40);
    run_base = -1;

    // Run with start pulses while busy and while done.
    do_start(base);
    wait_until(base + 5);
    pulse_start();
    wait_until(base + 34);
    pulse_start();
    wait_until(base + 40);
    run_base = -1;

    // Reset in cycle 15 of a run.
    do_start(base);
    wait_until(base + 14);
    @(posedge clk);
    #2;
    rst      = 1'b1;
    run_base = -1;
    flush_queues();
    @(negedge clk);
    check_all_zero("reset_midrun");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Rerun after reset.
    do_start(base);
    wait_until(base + 40);
    run_base = -1;

    checks++;
    if (exp_rd.size() != 0) begin
      errors++;
      $display("FAIL rd_missing got=%0d pending want=0", exp_rd.size());
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL wr_missing got=%0d pending want=0", exp_wr.size());
    end
    checks++;
    if (exp_done.size() != 0) begin
      errors++;
      $display("FAIL done_missing got=%0d pending want=0", exp_done.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ntt_mem_sched.md
Name: ntt_mem_sched

Overview:
- Address/control scheduler that sequences one `bram_p` instance through an in-place radix-2 NTT.
- Covers all stages, one coefficient read per cycle.
- Generates read address, twiddle index and stage number for the butterfly unit.
- Writes results back to the same addresses after a fixed pipeline latency, draining between stages to avoid read-after-write hazards.

Parameters:
- Q_DEPTH, 8, log2 of memory depth; addresses are Q_DEPTH bits wide.
- NUM_STAGES, 8, number of NTT stages; must satisfy 1 ≤ NUM_STAGES ≤ Q_DEPTH.
- BFLY_LAT, 4, butterfly pipeline latency in cycles (≥1).
- PIPE_LAT (localparam), BFLY_LAT+1, total latency from rd_addr to wr_addr; the +1 is the BRAM registered read.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a full NTT; ignored unless idle.
- busy  out  1  high from the cycle after start is accepted until done is asserted (inclusive).
- done  out  1  one-cycle pulse when the final write has been issued.
- rd_en  out  1  read address valid this cycle.
- rd_addr  out  Q_DEPTH  BRAM read address.
- stage  out  $clog2(NUM_STAGES+1)  stage of current read.
- tw_idx  out  Q_DEPTH  twiddle ROM index for current read.
- wr_en  out  1  BRAM write enable (rd_en delayed PIPE_LAT).
- wr_addr  out  Q_DEPTH  BRAM write address (rd_addr delayed PIPE_LAT).

Behaviour:
- Reset, async and active-high: state=IDLE, counter=0, stage=0, drain counter=0, delay line cleared; all outputs 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 → RUN with c=0, stage=0. start=0 → stay.
- RUN: rd_en=1, c increments each cycle. When c=2^Q_DEPTH-1 (wraps to 0) → DRAIN with drain count=0.
- DRAIN: rd_en=0 for exactly PIPE_LAT cycles. Then:
  - stage<NUM_STAGES-1 → stage+1, RUN.
  - otherwise → DONE.
- DONE: done=1 and busy=1 for one cycle, then → IDLE (busy=0).
- Address rule: rd_addr = rotl_{Q_DEPTH}(c, stage). At stage 0, rd_addr=c.
- Twiddle rule: tw_idx = 0 at stage 0; otherwise c >> (Q_DEPTH-stage), zero-extended.
- Write path: shift register of depth PIPE_LAT carrying {rd_en, rd_addr}. wr_en/wr_addr are its tail. The delay line keeps shifting during DRAIN and DONE, so every read produces exactly one write.
- Hazard guarantee: the last write of a stage commits at or before the posedge preceding the first read of the next stage.
- Latency: with start sampled at edge 0, the first rd_en is visible in cycle 1. done is visible in cycle NUM_STAGES*(2^Q_DEPTH+PIPE_LAT)+1.
- start while busy: ignored; no restart or queueing.
- start in the same cycle as done: ignored (not IDLE).
- Reset mid-operation: immediately returns to the reset state. In-flight writes are discarded (wr_en=0).
- Counter wrap is modulo 2^Q_DEPTH with no overflow flag.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/RUN/DRAIN/DONE).
  - PIPE_LAT derivation.
  - rotl function.
- One natural sub-module: ntt_delay_line, a parameterised width/depth shift register with async reset. It is reusable for aligning twiddle and data paths.

Test Plan (Q_DEPTH=3, NUM_STAGES=3, BFLY_LAT=2, PIPE_LAT=3):
- Reset then idle: start=0 for 20 cycles → busy=rd_en=wr_en=done=0 throughout.
- Full run: start pulse at edge 0 → rd_en cycles 1-8, 12-19, 23-30; done only in cycle 34; busy cycles 1-34.
- Address order:
  - stage 0 rd_addr=0,1,2,...,7.
  - stage 1 rd_addr=0,2,4,6,1,3,5,7.
  - stage 1 tw_idx=0,0,0,0,1,1,1,1.
  - stage 2 tw_idx=0,0,1,1,2,2,3,3.
- Write alignment: every wr_addr equals the rd_addr from 3 cycles earlier. wr_en count is 24 per run. The last write is in cycle 33.
- start pulses at cycles 5 and 34 (during busy/done) → ignored; a single done is seen at 34.
- rst asserted in cycle 15 → all outputs 0 in the same cycle. No further wr_en. A subsequent start reruns from stage 0 with correct timing.
